// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multicycle ALU with valid/ready handshake and iterative shift-add multiplier
// Single-cycle codes resolve at accept; MUL runs WIDTH shift-add steps in CALC before DONE.
module ula_multiciclo #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [3:0]       CodeULA,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Res,
    output logic [3:0]       FlagReg,
    output logic             Busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_BEZ = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [3:0]           flag_q, flag_d;

    logic [WIDTH:0]       add_ext, sub_ext, sll_ext, srl_ext, sra_ext;
    logic [SHW-1:0]       sh_amt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_v, alu_c, alu_zn;
    logic [3:0]           alu_flags;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign sh_amt  = OpB[SHW-1:0];
    assign add_ext = {1'b0, OpA} + {1'b0, OpB};
    assign sub_ext = {1'b0, OpA} - {1'b0, OpB};
    // One guard bit beside the operand catches the last bit shifted out.
    assign sll_ext = {1'b0, OpA} << sh_amt;
    assign srl_ext = {OpA, 1'b0} >> sh_amt;
    assign sra_ext = $unsigned($signed({OpA, 1'b0}) >>> sh_amt);

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_zn  = 1'b1;
        case (CodeULA)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (OpA[WIDTH-1] == OpB[WIDTH-1]) && (add_ext[WIDTH-1] != OpA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (OpA[WIDTH-1] != OpB[WIDTH-1]) && (sub_ext[WIDTH-1] != OpA[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(OpA) < $signed(OpB)};
            OP_AND: alu_res = OpA & OpB;
            OP_OR:  alu_res = OpA | OpB;
            OP_XOR: alu_res = OpA ^ OpB;
            OP_BEZ: begin
                alu_res = OpB;
                alu_zn  = 1'b0;
            end
            OP_SLL: begin
                alu_res = sll_ext[WIDTH-1:0];
                alu_c   = sll_ext[WIDTH];
            end
            OP_SRL: begin
                alu_res = srl_ext[WIDTH:1];
                alu_c   = srl_ext[0];
            end
            OP_SRA: begin
                alu_res = sra_ext[WIDTH:1];
                alu_c   = sra_ext[0];
            end
            default: alu_zn = 1'b0;
        endcase
    end

    always_comb begin
        alu_flags = 4'b0000;
        if (CodeULA == OP_BEZ) begin
            alu_flags = {OpA == '0, 3'b000};
        end else if (alu_zn) begin
            alu_flags = {alu_res == '0, alu_res[WIDTH-1], alu_v, alu_c};
        end
    end

    // Accumulator holds {partial product high half, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (CodeULA == OP_MUL) begin
                        mcand_d = OpA;
                        acc_d   = {{WIDTH{1'b0}}, OpB};
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        res_d   = alu_res;
                        flag_d  = alu_flags;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1)) begin
                    res_d   = mul_next[WIDTH-1:0];
                    flag_d  = {mul_next[WIDTH-1:0] == '0, mul_next[WIDTH-1],
                               mul_next[2*WIDTH-1:WIDTH] != '0, 1'b0};
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Busy     = (state_q != IDLE);
    assign Res      = res_q;
    assign FlagReg  = flag_q;

endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (legal 8..32, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 InValid  input  1  operation request valid.
REQ-006 InReady  output  1  block accepts a request this cycle.
REQ-007 OpA, OpB  input  WIDTH each  operands.
REQ-008 CodeULA  input  4  operation code.
REQ-009 OutValid  output  1  Res/FlagReg hold a completed result.
REQ-010 OutReady  input  1  consumer takes the result this cycle.
REQ-011 Res  output  WIDTH  registered result.
REQ-012 FlagReg  output  4  registered flags [3]=Z zero, [2]=N negative, [1]=V overflow, [0]=C carry.
REQ-013 Busy  output  1  high while the state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE; InReady = (state==IDLE).
REQ-015 Accept SHALL occur on a cycle with InValid=1 and InReady=1; OpA, OpB, CodeULA are latched then; inputs SHALL be ignored in all other cycles.
REQ-016 Single-cycle codes SHALL go IDLE->DONE with OutValid=1 the cycle after accept (latency 1).
REQ-017 Codes: 0000 ADD, 0001 SUB, 0010 SLT, 0011 AND, 0100 OR, 0101 XOR, 0110 BEZ, 0111 NOP, 1000 MUL, 1001 SLL, 1010 SRL, 1011 SRA; 1100-1111 SHALL behave as NOP.
REQ-018 ADD: Res=A+B mod 2^WIDTH; C=carry out; V=signed overflow.
REQ-019 SUB: Res=A-B mod 2^WIDTH; C=1 when A<B unsigned (borrow); V=signed overflow.
REQ-020 SLT: Res=1 when A<B signed, else 0; V=C=0.
REQ-021 AND/OR/XOR: bitwise; V=C=0.
REQ-022 BEZ: Res=B; Z=(A==0); N=V=C=0.
REQ-023 NOP/undefined: Res=0, all flags 0, still latency 1 with handshake.
REQ-024 SLL/SRL/SRA: shift A by B[SHW-1:0]; C=last bit shifted out, 0 when amount is 0; V=0.
REQ-025 MUL: iterative unsigned shift-add, one multiplier bit per cycle in CALC, exactly WIDTH CALC cycles, OutValid asserted WIDTH+1 cycles after accept.
REQ-026 MUL: Res=low WIDTH bits of product; V=1 when high WIDTH bits nonzero; C=0.
REQ-027 Z and N SHALL be derived from the final computed Res (Z=Res==0, N=Res[WIDTH-1]) except BEZ/NOP; never from the previous Res.
REQ-028 DONE SHALL hold Res, FlagReg, OutValid=1 stable until OutReady=1; on that cycle state returns to IDLE and OutValid drops the next cycle.
REQ-029 OutReady while not in DONE SHALL have no effect.
REQ-030 No new request SHALL be accepted in the cycle the result is taken (InReady goes high in the following cycle).

Reset
REQ-031 RST=0 SHALL immediately force state IDLE, Res=0, FlagReg=0, OutValid=0, Busy=0, InReady=1, MUL accumulator/counter=0.
REQ-032 RST asserted mid-MUL or in DONE SHALL discard the operation; no OutValid follows after release.
REQ-033 First accept SHALL be possible on the first rising edge after RST deasserts.

Verification
REQ-034 ADD 0x7FFF+0x0001 -> Res 0x8000, FlagReg 0b0110 (N,V), OutValid 1 cycle after accept.
REQ-035 SUB 0x0003-0x0005 -> Res 0xFFFE, FlagReg 0b0101 (N,C); SLT 0xFFFF,0x0001 -> Res 0x0001, FlagReg 0b0000.
REQ-036 MUL 0x0100*0x0100 -> Res 0x0000, FlagReg 0b1010 (Z,V), OutValid exactly 17 cycles after accept, InReady=0 and Busy=1 throughout.
REQ-037 OutReady=0 for 5 cycles in DONE with InValid=1 and changing operands -> Res/FlagReg unchanged, InReady=0, no accept.
REQ-038 RST low during 5th MUL CALC cycle -> OutValid=0, InReady=1, Res=0 without a clock edge; following ADD 2+3 -> Res 0x0005.
REQ-039 SRA 0x8001 by 1 -> Res 0xC000, FlagReg 0b0101; BEZ A=0, B=0x1234 -> Res 0x1234, FlagReg 0b1000.
